// File: rtl/req_gnt_sequencer.sv
// Request/grant sequencer: counts busy cycles after an accepted req, pulses gnt once, keeps a 1-deep request queue.
// Optional wait timeout enabled by defining REQ_GNT_TIMEOUT_EN.
module req_gnt_sequencer #(
  parameter int BUSY_COUNT = 3,
  parameter int CNT_W      = 8,
  parameter int TIMEOUT    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             busy,
  output logic             gnt,
  output logic             pending,
  output logic [CNT_W-1:0] busy_cnt,
  output logic             req_drop,
  output logic             timeout_err
);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, GRANT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             q_valid, q_nxt;
  logic             drop_q, drop_nxt;
  logic             hit;
  logic             expire;

  // hit: this edge delivers the BUSY_COUNT-th busy sample
  assign hit = (state == WAIT_BUSY) && busy && (cnt == CNT_W'(BUSY_COUNT - 1));

`ifdef REQ_GNT_TIMEOUT_EN
  logic [CNT_W-1:0] to_cnt;
  logic             tmo_q;

  // Grant wins over an expiry on the same edge
  assign expire = (state == WAIT_BUSY) && (to_cnt == CNT_W'(TIMEOUT - 1)) && !hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
      tmo_q  <= 1'b0;
    end else begin
      to_cnt <= (state == WAIT_BUSY && state_nxt == WAIT_BUSY) ? to_cnt + 1'b1 : '0;
      tmo_q  <= expire;
    end
  end

  assign timeout_err = tmo_q;
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      q_valid <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      q_valid <= q_nxt;
      drop_q  <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    q_nxt     = q_valid;
    drop_nxt  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (req) state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (busy) cnt_nxt = cnt + 1'b1;
        if (req) begin
          if (q_valid) drop_nxt = 1'b1;
          else         q_nxt    = 1'b1;
        end
        if (hit) begin
          state_nxt = GRANT;
        end else if (expire) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          q_nxt     = 1'b0;
          drop_nxt  = 1'b0;
        end
      end
      GRANT: begin
        // A req here with an empty queue is captured and consumed at once
        cnt_nxt   = '0;
        q_nxt     = 1'b0;
        drop_nxt  = req && q_valid;
        state_nxt = (q_valid || req) ? WAIT_BUSY : IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        q_nxt     = 1'b0;
      end
    endcase
  end

  always_comb begin
    gnt      = (state == GRANT);
    pending  = (state != IDLE);
    busy_cnt = cnt;
    req_drop = drop_q;
  end

endmodule

// File: tb/tb_req_gnt_sequencer.sv
// Directed bench for req_gnt_sequencer: BUSY_COUNT=3, TIMEOUT=10; timeout cases run when REQ_GNT_TIMEOUT_EN is defined.
module tb_req_gnt_sequencer;

  localparam int BC = 3;
  localparam int CW = 8;
  localparam int TO = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req = 1'b0;
  logic          busy = 1'b0;
  logic          gnt, pending, req_drop, timeout_err;
  logic [CW-1:0] busy_cnt;

  int checks = 0;
  int errors = 0;
  int gnt_total = 0;

  req_gnt_sequencer #(.BUSY_COUNT(BC), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .busy(busy), .gnt(gnt),
    .pending(pending), .busy_cnt(busy_cnt), .req_drop(req_drop),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (gnt) gnt_total <= gnt_total + 1;

  // Drive one cycle of inputs, then land just after the edge that samples them
  task automatic cyc(input logic r, input logic b);
    req  = r;
    busy = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic g, input logic p,
                     input int c, input logic d, input logic t);
    checks++;
    assert (gnt === g) else begin
      errors++; $error("FAIL %s gnt observed=%b expected=%b", tag, gnt, g);
    end
    checks++;
    assert (pending === p) else begin
      errors++; $error("FAIL %s pending observed=%b expected=%b", tag, pending, p);
    end
    checks++;
    assert (busy_cnt === CW'(c)) else begin
      errors++; $error("FAIL %s busy_cnt observed=%0d expected=%0d", tag, busy_cnt, c);
    end
    checks++;
    assert (req_drop === d) else begin
      errors++; $error("FAIL %s req_drop observed=%b expected=%b", tag, req_drop, d);
    end
    checks++;
    assert (timeout_err === t) else begin
      errors++; $error("FAIL %s timeout_err observed=%b expected=%b", tag, timeout_err, t);
    end
  endtask

  initial begin
    int n0;
    // Reset
    reset = 1'b1;
    cyc(1, 1);
    cyc(1, 1);
    chk("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    cyc(0, 0);
    chk("idle", 0, 0, 0, 0, 0);

    // Basic grant: req c1, busy c3/c5/c7 -> gnt in c8
    n0 = gnt_total;
    cyc(1, 0); chk("basic c2", 0, 1, 0, 0, 0);
    cyc(0, 0); chk("basic c3", 0, 1, 0, 0, 0);
    cyc(0, 1); chk("basic c4", 0, 1, 1, 0, 0);
    cyc(0, 0); chk("basic c5", 0, 1, 1, 0, 0);
    cyc(0, 1); chk("basic c6", 0, 1, 2, 0, 0);
    cyc(0, 0); chk("basic c7", 0, 1, 2, 0, 0);
    cyc(0, 1); chk("basic c8", 1, 1, 3, 0, 0);
    cyc(0, 0); chk("basic c9", 0, 0, 0, 0, 0);
    checks++;
    assert (gnt_total - n0 === 1) else begin
      errors++; $error("FAIL basic gnt_count observed=%0d expected=1", gnt_total - n0);
    end

    // Consecutive busy; busy during GRANT is ignored
    cyc(1, 0); chk("consec c2", 0, 1, 0, 0, 0);
    cyc(0, 0); chk("consec c3", 0, 1, 0, 0, 0);
    cyc(0, 1); chk("consec c4", 0, 1, 1, 0, 0);
    cyc(0, 1); chk("consec c5", 0, 1, 2, 0, 0);
    cyc(0, 1); chk("consec c6", 1, 1, 3, 0, 0);
    cyc(0, 1); chk("consec c7", 0, 0, 0, 0, 0);
    cyc(0, 0); chk("consec c8", 0, 0, 0, 0, 0);

    // Queue and drop: req c1, c4 (queued), c6 (dropped in GRANT)
    n0 = gnt_total;
    cyc(1, 0); chk("queue c2", 0, 1, 0, 0, 0);
    cyc(0, 1); chk("queue c3", 0, 1, 1, 0, 0);
    cyc(0, 1); chk("queue c4", 0, 1, 2, 0, 0);
    cyc(1, 0); chk("queue c5", 0, 1, 2, 0, 0);
    cyc(0, 1); chk("queue c6", 1, 1, 3, 0, 0);
    cyc(1, 0); chk("queue c7", 0, 1, 0, 1, 0);
    cyc(0, 1); chk("queue c8", 0, 1, 1, 0, 0);
    cyc(0, 1); chk("queue c9", 0, 1, 2, 0, 0);
    cyc(0, 1); chk("queue c10", 1, 1, 3, 0, 0);
    cyc(0, 0); chk("queue c11", 0, 0, 0, 0, 0);
    cyc(0, 0); chk("queue c12", 0, 0, 0, 0, 0);
    checks++;
    assert (gnt_total - n0 === 2) else begin
      errors++; $error("FAIL queue gnt_count observed=%0d expected=2", gnt_total - n0);
    end

    // Busy on the accepting edge is not counted; req in GRANT with empty queue
    cyc(1, 1); chk("b2b accept", 0, 1, 0, 0, 0);
    cyc(0, 1); chk("b2b w1", 0, 1, 1, 0, 0);
    cyc(0, 1); chk("b2b w2", 0, 1, 2, 0, 0);
    cyc(0, 1); chk("b2b gnt1", 1, 1, 3, 0, 0);
    cyc(1, 0); chk("b2b regrant", 0, 1, 0, 0, 0);
    cyc(0, 1); chk("b2b x1", 0, 1, 1, 0, 0);
    cyc(0, 1); chk("b2b x2", 0, 1, 2, 0, 0);
    cyc(0, 1); chk("b2b gnt2", 1, 1, 3, 0, 0);
    cyc(0, 0); chk("b2b idle", 0, 0, 0, 0, 0);

    // Reset mid-WAIT_BUSY aborts, then a fresh request is serviced
    n0 = gnt_total;
    cyc(1, 0); chk("rst c2", 0, 1, 0, 0, 0);
    cyc(0, 0); chk("rst c3", 0, 1, 0, 0, 0);
    cyc(0, 1); chk("rst c4", 0, 1, 1, 0, 0);
    reset = 1'b1;
    cyc(0, 1); chk("rst c5", 0, 0, 0, 0, 0);
    reset = 1'b0;
    cyc(0, 0); chk("rst c6", 0, 0, 0, 0, 0);
    checks++;
    assert (gnt_total - n0 === 0) else begin
      errors++; $error("FAIL rst gnt_count observed=%0d expected=0", gnt_total - n0);
    end
    cyc(1, 0); chk("rst c7", 0, 1, 0, 0, 0);
    cyc(0, 1); chk("rst c8", 0, 1, 1, 0, 0);
    cyc(0, 1); chk("rst c9", 0, 1, 2, 0, 0);
    cyc(0, 1); chk("rst c10", 1, 1, 3, 0, 0);
    cyc(0, 0); chk("rst c11", 0, 0, 0, 0, 0);

`ifdef REQ_GNT_TIMEOUT_EN
    // Timeout: only two busy pulses, expiry after TO cycles in WAIT_BUSY
    n0 = gnt_total;
    cyc(1, 0); chk("tmo1 accept", 0, 1, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) cyc(0, (i == 1 || i == 3));
    chk("tmo1 pre", 0, 1, 2, 0, 0);
    cyc(1, 0); chk("tmo1 abort", 0, 0, 0, 0, 1);
    cyc(0, 0); chk("tmo1 after", 0, 0, 0, 0, 0);
    checks++;
    assert (gnt_total - n0 === 0) else begin
      errors++; $error("FAIL tmo1 gnt_count observed=%0d expected=0", gnt_total - n0);
    end

    // Nth busy on the expiry edge: grant wins
    cyc(1, 0); chk("tmo2 accept", 0, 1, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) cyc(0, (i == 0 || i == 5));
    chk("tmo2 pre", 0, 1, 2, 0, 0);
    cyc(0, 1); chk("tmo2 gnt", 1, 1, 3, 0, 0);
    cyc(0, 0); chk("tmo2 after", 0, 0, 0, 0, 0);
`else
    // Without timeout, WAIT_BUSY holds indefinitely
    cyc(1, 0); chk("notmo accept", 0, 1, 0, 0, 0);
    for (int i = 0; i < 3 * TO; i++) cyc(0, (i == 4));
    chk("notmo hold", 0, 1, 1, 0, 0);
    cyc(0, 1); chk("notmo w2", 0, 1, 2, 0, 0);
    cyc(0, 1); chk("notmo gnt", 1, 1, 3, 0, 0);
    cyc(0, 0); chk("notmo idle", 0, 0, 0, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
